// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Types and constants shared by the rv32i fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

   // One fetched instruction together with its architectural tags
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [63:0] order;
   } fetch_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_circ_queue.sv
`default_nettype none
// ============================================================================
// Module      : circ_queue
// Description : Generic circular FIFO with push, pop, clear and occupancy.
//               Storage is not reset; only pointers and count are.
// Revision    : 1.0 - initial release
// ============================================================================
module circ_queue #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_data_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_push;
   logic             w_pop;

   // Qualify requests and compute next pointer/count values
   always_comb begin
      w_pop   = pop_i & (count_q != '0);
      w_push  = push_i & ((count_q != CNT_W'(DEPTH)) | w_pop);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) tail_d = tail_q + PTR_W'(1);
         if (w_pop)  head_d = head_q + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage write port
   always_ff @(posedge clk) begin
      if (w_push && !clear_i) mem_q[tail_q] <= push_data_i;
   end

   assign head_data_o = mem_q[head_q];
   assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Decoupled rv32i instruction fetch front end. Keeps up to
//               MAX_INFLIGHT imem reads outstanding, buffers responses in a
//               DEPTH-entry queue tagged with pc/order, and discards stale
//               responses after a redirect.
//               Optional: FETCH_QUEUE_BYPASS_EN presents a response on deq_*
//               in its arrival cycle when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import rv32i_types::*;
#(
   parameter int          DEPTH        = 8,
   parameter int          MAX_INFLIGHT = 4,
   parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [31:0]                imem_addr,
   output logic [3:0]                 imem_rmask,
   input  logic [31:0]                imem_rdata,
   input  logic                       imem_resp,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   input  logic [63:0]                redirect_order,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [31:0]                deq_inst,
   output logic [31:0]                deq_pc,
   output logic [31:0]                deq_pc_next,
   output logic [63:0]                deq_order,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int INF_W   = $clog2(MAX_INFLIGHT+1);
   localparam int ENTRY_W = $bits(fetch_entry_t);

   // Request order is implied by the in-order memory, so order is only
   // tracked on the response side.
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        resp_pc_q, resp_pc_d;
   logic [63:0]        resp_order_q, resp_order_d;
   logic [INF_W-1:0]   inflight_q, inflight_d;
   logic [INF_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic [31:0]        w_occupancy;
   logic               w_issue;
   logic               w_resp_live;
   logic               w_q_valid;
   logic               w_bypass;
   logic               w_push;
   logic               w_pop;
   fetch_entry_t       w_push_entry;
   fetch_entry_t       w_q_head;
   fetch_entry_t       w_deq_entry;
   logic [ENTRY_W-1:0] w_q_head_bits;

   // Issue, response classification, bypass and dequeue steering
   always_comb begin
      // Outstanding responses hold reserved slots so the queue cannot overflow
      w_occupancy  = 32'(inflight_q) + 32'(count);
      w_issue      = ~rst & ~redirect_valid
                   & (32'(inflight_q) < 32'(MAX_INFLIGHT))
                   & (w_occupancy < 32'(DEPTH));
      w_resp_live  = imem_resp & (drop_cnt_q == '0) & ~redirect_valid;
      w_q_valid    = (count != '0) & ~redirect_valid;
`ifdef FETCH_QUEUE_BYPASS_EN
      w_bypass     = w_resp_live & (count == '0);
`else
      w_bypass     = 1'b0;
`endif
      w_push_entry = '{inst: imem_rdata, pc: resp_pc_q, order: resp_order_q};
      w_deq_entry  = w_bypass ? w_push_entry : w_q_head;
      w_push       = w_resp_live & ~(w_bypass & deq_ready);
      w_pop        = w_q_valid & deq_ready;
      imem_addr    = fetch_pc_q;
      imem_rmask   = w_issue ? 4'hF : 4'h0;
      deq_valid    = w_q_valid | w_bypass;
      deq_inst     = w_deq_entry.inst;
      deq_pc       = w_deq_entry.pc;
      deq_pc_next  = w_deq_entry.pc + 32'd4;
      deq_order    = w_deq_entry.order;
   end

   // Next-state for pc/order tracking and inflight/drop accounting
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      resp_pc_d    = resp_pc_q;
      resp_order_d = resp_order_q;
      drop_cnt_d   = drop_cnt_q;
      inflight_d   = inflight_q + INF_W'(w_issue) - INF_W'(imem_resp);
      if (redirect_valid) begin
         fetch_pc_d   = redirect_pc;
         resp_pc_d    = redirect_pc;
         resp_order_d = redirect_order;
         // Everything still outstanding after this cycle is stale
         drop_cnt_d   = inflight_q - INF_W'(imem_resp);
      end else begin
         if (w_issue) fetch_pc_d = fetch_pc_q + 32'd4;
         if (w_resp_live) begin
            resp_pc_d    = resp_pc_q + 32'd4;
            resp_order_d = resp_order_q + 64'd1;
         end
         if (imem_resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - INF_W'(1);
      end
   end

   // Front-end state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         resp_order_q <= '0;
         inflight_q   <= '0;
         drop_cnt_q   <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_order_q <= resp_order_d;
         inflight_q   <= inflight_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   circ_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (redirect_valid),
      .push_i      (w_push),
      .push_data_i (w_push_entry),
      .pop_i       (w_pop),
      .head_data_o (w_q_head_bits),
      .count_o     (count)
   );

   assign w_q_head = fetch_entry_t'(w_q_head_bits);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A memory model answers
//               requests in order after a programmable latency; an
//               instruction-stream model predicts every dequeued entry.
//               Honours FETCH_QUEUE_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam int          DEPTH = 8;
   localparam int          MAXI  = 4;
   localparam logic [31:0] RPC   = 32'h1eceb000;
   localparam logic [31:0] MASK  = 32'hA5A5A5A5;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit          BYP   = 1'b1;
`else
   localparam bit          BYP   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata = '0;
   logic        imem_resp = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [63:0] redirect_order = '0;
   logic        deq_valid;
   logic        deq_ready = 1'b0;
   logic [31:0] deq_inst;
   logic [31:0] deq_pc;
   logic [31:0] deq_pc_next;
   logic [63:0] deq_order;
   logic [3:0]  count;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_order(redirect_order),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pc_next(deq_pc_next),
      .deq_order(deq_order), .count(count)
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        memq[$];
   int          cyc = 0, epoch = 0, lat = 1;
   bit          mem_en = 1'b1, rdy = 1'b0;
   int          cnt_m = 0;
   logic [31:0] fetch_m = RPC, exp_pc = RPC;
   logic [63:0] exp_ord = '0;
   int          n_cmp = 0, n_bad = 0;
   int          max_out, max_cnt, n_deq, n_stale, first_resp_cyc, first_dv_cyc;
   int          iss_cyc[$];
   logic [31:0] log_pc[$];
   logic [63:0] log_ord[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Compare DUT outputs with the stream model, then advance the model
   task automatic model_cycle();
      bit fresh, issue_exp, dv_exp, fire;
      assert (!imem_resp || memq.size() != 0);
      fresh     = imem_resp && (memq[0].epoch == epoch);
      issue_exp = !redirect_valid && (memq.size() < MAXI) && (memq.size() + cnt_m < DEPTH);
      chk("issue_rmask", {60'd0, imem_rmask}, issue_exp ? 64'hF : 64'h0);
      if (imem_rmask == 4'hF) chk("issue_addr", {32'd0, imem_addr}, {32'd0, fetch_m});
      chk("count", {60'd0, count}, 64'(cnt_m));
      dv_exp = !redirect_valid && ((cnt_m != 0) || (BYP && fresh));
      chk("deq_valid", {63'd0, deq_valid}, {63'd0, dv_exp});
      fire = deq_valid && deq_ready && !redirect_valid;
      if (fire) begin
         chk("deq_pc", {32'd0, deq_pc}, {32'd0, exp_pc});
         chk("deq_pc_next", {32'd0, deq_pc_next}, {32'd0, exp_pc + 32'd4});
         chk("deq_inst", {32'd0, deq_inst}, {32'd0, exp_pc ^ MASK});
         chk("deq_order", deq_order, exp_ord);
         log_pc.push_back(deq_pc);
         log_ord.push_back(deq_order);
         n_deq++;
      end
      if (deq_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
      if (fresh && first_resp_cyc < 0) first_resp_cyc = cyc;
      if (imem_resp) begin
         if (!fresh) n_stale++;
         void'(memq.pop_front());
      end
      if (redirect_valid) begin
         epoch++;
         cnt_m   = 0;
         fetch_m = redirect_pc;
         exp_pc  = redirect_pc;
         exp_ord = redirect_order;
      end else begin
         if (imem_rmask == 4'hF) begin
            memq.push_back('{addr: imem_addr, epoch: epoch, due: cyc + lat});
            iss_cyc.push_back(cyc);
            fetch_m = fetch_m + 32'd4;
         end
         cnt_m = cnt_m + int'(fresh) - int'(fire);
         if (fire) begin
            exp_pc  = exp_pc + 32'd4;
            exp_ord = exp_ord + 64'd1;
         end
      end
      if (memq.size() > max_out) max_out = memq.size();
      if (cnt_m > max_cnt) max_cnt = cnt_m;
   endtask

   // One clock: drive inputs at the falling edge, settle, compare
   task automatic step(input bit r, input bit redir, input logic [31:0] rpc, input logic [63:0] rord);
      @(negedge clk);
      rst = r;
      if (!r && mem_en && memq.size() != 0 && memq[0].due <= cyc) begin
         imem_resp  = 1'b1;
         imem_rdata = memq[0].addr ^ MASK;
      end else begin
         imem_resp  = 1'b0;
         imem_rdata = '0;
      end
      redirect_valid = redir;
      redirect_pc    = rpc;
      redirect_order = rord;
      deq_ready      = rdy;
      #1;
      if (!rst) model_cycle();
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, '0, '0);
         if (i > 0) begin
            chk("rst_rmask", {60'd0, imem_rmask}, 64'h0);
            chk("rst_deq_valid", {63'd0, deq_valid}, 64'h0);
            chk("rst_count", {60'd0, count}, 64'h0);
         end
      end
      memq.delete();
      iss_cyc.delete();
      log_pc.delete();
      log_ord.delete();
      epoch++;
      cnt_m = 0; fetch_m = RPC; exp_pc = RPC; exp_ord = '0;
      max_out = 0; max_cnt = 0; n_deq = 0; n_stale = 0;
      first_resp_cyc = -1; first_dv_cyc = -1;
   endtask

   initial begin
      bit hit;
      int n_a, d0;

      // Streaming with 1-cycle memory and decode always ready
      lat = 1; mem_en = 1'b1; rdy = 1'b1;
      do_reset();
      run(40);
      chk("t1_pc0", {32'd0, log_pc[0]}, 64'h1eceb000);
      chk("t1_pc1", {32'd0, log_pc[1]}, 64'h1eceb004);
      chk("t1_pc2", {32'd0, log_pc[2]}, 64'h1eceb008);
      chk("t1_ord2", log_ord[2], 64'd2);
      chk("t1_inflight_le4", 64'(max_out <= MAXI), 64'd1);
      chk("t1_resp_to_deq", 64'(first_dv_cyc - first_resp_cyc), BYP ? 64'd0 : 64'd1);

      // Decode stalled: queue fills to DEPTH and issue stops, then drains
      rdy = 1'b0; max_cnt = 0;
      run(30);
      chk("t2_max_count", 64'(max_cnt), 64'd8);
      chk("t2_full_count", {60'd0, count}, 64'd8);
      chk("t2_no_issue", {60'd0, imem_rmask}, 64'h0);
      rdy = 1'b1; d0 = n_deq;
      run(30);
      chk("t2_drained", 64'(n_deq - d0 >= 8), 64'd1);

      // 5-cycle memory: inflight cap and resume after first response
      lat = 5; rdy = 1'b1;
      do_reset();
      run(40);
      chk("t3_max_inflight", 64'(max_out), 64'd4);
      chk("t3_resume", 64'(iss_cyc[4] - first_resp_cyc), 64'd1);

      // Redirect with 3 requests in flight and 2 entries queued
      lat = 1; mem_en = 1'b1; rdy = 1'b0;
      do_reset();
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (cnt_m >= 2) mem_en = 1'b0;
         if (memq.size() == 3 && cnt_m == 2) begin
            hit = 1'b1;
            break;
         end
         step(1'b0, 1'b0, '0, '0);
      end
      chk("t4_setup_reached", {63'd0, hit}, 64'd1);
      n_stale = 0;
      log_pc.delete(); log_ord.delete();
      step(1'b0, 1'b1, 32'h1eceb100, 64'd20);
      mem_en = 1'b1; rdy = 1'b1;
      run(30);
      chk("t4_stale_dropped", 64'(n_stale), 64'd3);
      chk("t4_first_pc", {32'd0, log_pc[0]}, 64'h1eceb100);
      chk("t4_first_ord", log_ord[0], 64'd20);
      chk("t4_second_pc", {32'd0, log_pc[1]}, 64'h1eceb104);

      // Redirect coinciding with a response, then a second redirect
      lat = 1; mem_en = 1'b0; rdy = 1'b1;
      do_reset();
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (memq.size() == 2) begin
            hit = 1'b1;
            break;
         end
         step(1'b0, 1'b0, '0, '0);
      end
      chk("t5_setup_reached", {63'd0, hit}, 64'd1);
      mem_en = 1'b1;
      log_pc.delete(); log_ord.delete();
      step(1'b0, 1'b1, 32'h1eceb200, 64'd100);
      chk("t5_resp_with_redirect", {63'd0, imem_resp}, 64'd1);
      step(1'b0, 1'b1, 32'h1eceb300, 64'd200);
      run(30);
      n_a = 0;
      foreach (log_pc[k]) if (log_pc[k] >= 32'h1eceb200 && log_pc[k] < 32'h1eceb300) n_a++;
      chk("t5_no_first_target", 64'(n_a), 64'd0);
      chk("t5_first_pc", {32'd0, log_pc[0]}, 64'h1eceb300);
      chk("t5_first_ord", log_ord[0], 64'd200);
      chk("t5_stale_dropped", 64'(n_stale), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end for the rv32i pipeline.
- Issues pipelined imem reads, keeping up to MAX_INFLIGHT requests outstanding.
- Buffers returned instructions in a DEPTH-entry circular queue, each tagged with pc, pc_next and RVFI order.
- Supplies decode through a valid/ready handshake and handles branch/jump redirects, including discarding stale in-flight responses.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- MAX_INFLIGHT, 4, maximum outstanding imem requests; >= 1, <= DEPTH.
- RESET_PC, 32'h1eceb000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_addr  out  32  request address; valid when imem_rmask != 0
- imem_rmask  out  4  4'hF on an issue cycle, else 4'h0
- imem_rdata  in  32  response data
- imem_resp  in  1  response strobe; responses arrive in request order
- redirect_valid  in  1  redirect from execute (branch/jump taken)
- redirect_pc  in  32  new fetch pc
- redirect_order  in  64  order of the first instruction at redirect_pc
- deq_valid  out  1  head entry available
- deq_ready  in  1  decode accepts head
- deq_inst  out  32  head instruction
- deq_pc  out  32  head pc
- deq_pc_next  out  32  head pc + 4
- deq_order  out  64  head RVFI order
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: rst is synchronous, active-high, clock clk.
  - fetch_pc=RESET_PC, fetch_order=0, resp_pc=RESET_PC, resp_order=0.
  - inflight=0, drop_cnt=0, head=tail=0, count=0.
  - Outputs: imem_rmask=0, deq_valid=0.
- Issue condition, combinational: ~rst & ~redirect_valid & inflight < MAX_INFLIGHT & (inflight + count) < DEPTH.
  - The DEPTH check reserves queue space for every outstanding response, so the queue can never overflow.
  - On issue: imem_addr=fetch_pc, imem_rmask=4'hF; next cycle fetch_pc += 4.
  - One issue per cycle at most; back-to-back issue is allowed.
- Response, on imem_resp:
  - If drop_cnt != 0: discard the data, drop_cnt -= 1.
  - Else: push {imem_rdata, resp_pc, resp_order} at tail; resp_pc += 4, resp_order += 1.
- inflight_next = inflight + issue - imem_resp.
- Dequeue:
  - deq_valid = (count != 0) & ~redirect_valid.
  - deq_valid & deq_ready pops the head.
  - Head fields are driven combinationally from storage; deq_pc_next = deq_pc + 4.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally; empty is count==0, full is count==DEPTH.
- Redirect cycle (redirect_valid=1):
  - No issue; no push; no pop.
  - Next state: queue cleared (head=tail, count=0).
  - fetch_pc=resp_pc=redirect_pc; fetch_order=resp_order=redirect_order.
  - drop_cnt = inflight - imem_resp, so every outstanding response is marked stale, including ones already pending drop.
  - The first issue from redirect_pc happens in the next cycle if the issue condition holds.
- Back-to-back redirects: the last one wins; drop accounting stays exact because drop_cnt is recomputed from inflight.
- Latency: push occurs on the response edge; deq_valid rises the cycle after imem_resp.
- Illegal: imem_resp while inflight==0; the bench flags it with an assertion.
- rst mid-operation returns every register to its reset value the next cycle.
  - Responses to pre-reset requests are outside the contract; memory is reset together with this block.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, a non-dropped imem_resp is presented on deq_* in the same cycle (deq_valid=1, deq_inst=imem_rdata, deq_pc=resp_pc, deq_order=resp_order).
  - If deq_ready=1 in that cycle, the entry is consumed and not pushed.
  - If deq_ready=0, it is pushed normally.
  - Suppressed when redirect_valid=1.
- Undefined: no bypass; response-to-deq_valid latency is exactly 1 cycle.

Decomposition:
- Shared package rv32i_types:
  - fetch_entry_t struct {inst[31:0], pc[31:0], order[63:0]}.
  - Constant RESET_PC_DEFAULT=32'h1eceb000.
- Sub-module: circ_queue #(WIDTH, DEPTH), a generic storage/pointer/count FIFO with push/pop/clear.
- fetch_queue owns the pc/order counters, the inflight/drop counters, and the bypass mux.

Test Plan:
- Reset, then deq_ready=1 and imem_resp 1 cycle after each request with rdata=pc^32'hA5A5A5A5 -> deq_pc sequence 1eceb000, 1eceb004, ...; deq_order 0,1,2,...; inflight never exceeds 4.
- deq_ready=0 and memory always responding -> count saturates at 8; imem_rmask stays 0 once inflight+count==8; then deq_ready=1 drains 8 entries in order.
- Memory latency 5 and MAX_INFLIGHT=4 -> exactly 4 requests outstanding; issue resumes the cycle after the first response.
- With 3 requests in flight and 2 queued, redirect_pc=32'h1eceb100, redirect_order=20 -> queue empties; the 3 stale responses are discarded; the first deq is pc 1eceb100, order 20.
- Redirect in the same cycle as imem_resp with inflight=2, then a second redirect 1 cycle later -> drop_cnt 1 then correct; only the second target's instructions appear.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, deq_ready=1 -> deq_valid in the same cycle as imem_resp and count stays 0; undefined -> deq_valid one cycle later.
